// File: rtl/usb20sr_refdes_irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register word addresses
// and the maximum number of interrupt sources.
package usb20sr_refdes_irq_ctrl_pkg;

    localparam int NUM_IRQ_MAX = 16;

    localparam logic [2:0] ADDR_PENDING   = 3'd0;
    localparam logic [2:0] ADDR_ENABLE    = 3'd1;
    localparam logic [2:0] ADDR_EDGE_SEL  = 3'd2;
    localparam logic [2:0] ADDR_CLEAR     = 3'd3;
    localparam logic [2:0] ADDR_FORCE     = 3'd4;
    localparam logic [2:0] ADDR_VECTOR    = 3'd5;
    localparam logic [2:0] ADDR_IRQ_COUNT = 3'd6;

endpackage

// File: rtl/usb20sr_refdes_irq_prienc.sv
// Lowest-index-wins priority encoder; valid is high when any request is set.
module usb20sr_refdes_irq_prienc #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    output logic [3:0]   idx,
    output logic         valid
);

    // Scan downward so the lowest set index is the last assignment to stick.
    always_comb begin
        idx   = 4'd0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = 4'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/usb20sr_refdes_irq_ctrl.sv
// Interrupt aggregator with edge/level sources, force/clear, priority vector
// and a saturating count of CPU interrupt assertions, on an Avalon-MM slave.
module usb20sr_refdes_irq_ctrl
    import usb20sr_refdes_irq_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    output logic               irq
);

    logic [NUM_IRQ-1:0] enable;
    logic [NUM_IRQ-1:0] edge_sel;
    logic [NUM_IRQ-1:0] pend_edge;
    logic [NUM_IRQ-1:0] force_latch;
    logic [NUM_IRQ-1:0] irq_dly;
    logic               first_cycle;
    logic [15:0]        irq_count;

    logic               wr;
    logic [NUM_IRQ-1:0] wr_bits;
    logic [NUM_IRQ-1:0] clr_bits;
    logic [NUM_IRQ-1:0] frc_bits;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] active;
    logic               any_active;
    logic [3:0]         vec_idx;
    logic               vec_valid;
    logic [15:0]        rd_mux;

    assign wr       = chipselect & ~write_n;
    assign wr_bits  = NUM_IRQ'(writedata);
    assign clr_bits = (wr && address == ADDR_CLEAR) ? wr_bits : '0;
    assign frc_bits = (wr && address == ADDR_FORCE) ? wr_bits : '0;

    // The first cycle after reset only primes the delayed copy, so a line that
    // was already high across reset is not mistaken for a fresh rising edge.
    assign rise = irq_in & ~irq_dly & ~{NUM_IRQ{first_cycle}};

    assign pending    = (edge_sel & pend_edge) | (~edge_sel & (irq_in | force_latch));
    assign active     = pending & enable;
    assign any_active = |active;

    usb20sr_refdes_irq_prienc #(.N(NUM_IRQ)) u_prienc (
        .req   (active),
        .idx   (vec_idx),
        .valid (vec_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable      <= '0;
            edge_sel    <= '0;
            pend_edge   <= '0;
            force_latch <= '0;
            irq_dly     <= '0;
            first_cycle <= 1'b1;
        end else begin
            first_cycle <= 1'b0;
            irq_dly     <= irq_in;
            if (wr && address == ADDR_ENABLE)   enable   <= wr_bits;
            if (wr && address == ADDR_EDGE_SEL) edge_sel <= wr_bits;
            // Sets are OR'd in after the clear so a same-cycle set wins.
            pend_edge   <= (pend_edge & ~clr_bits) | (edge_sel & (rise | frc_bits));
            force_latch <= (force_latch & ~clr_bits) | (~edge_sel & frc_bits);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq       <= 1'b0;
            irq_count <= 16'd0;
        end else begin
            irq <= any_active;
            if (wr && address == ADDR_IRQ_COUNT)
                irq_count <= 16'd0;
            else if (any_active && !irq && irq_count != 16'hFFFF)
                irq_count <= irq_count + 16'd1;
        end
    end

    always_comb begin
        rd_mux = 16'd0;
        case (address)
            ADDR_PENDING:   rd_mux = 16'(pending);
            ADDR_ENABLE:    rd_mux = 16'(enable);
            ADDR_EDGE_SEL:  rd_mux = 16'(edge_sel);
            ADDR_VECTOR:    rd_mux = {vec_valid, 11'd0, vec_idx};
            ADDR_IRQ_COUNT: rd_mux = irq_count;
            default:        rd_mux = 16'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= 16'd0;
        else          readdata <= rd_mux;
    end

endmodule

// File: tb/tb_usb20sr_refdes_irq_ctrl.sv
// Directed bench for the interrupt controller; inputs change on the falling
// edge and outputs are sampled on the falling edge or just after a change.
module tb_usb20sr_refdes_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  irq_in;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    int total = 0;
    int bad   = 0;

    usb20sr_refdes_irq_ctrl #(.NUM_IRQ(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .irq_in     (irq_in),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    logic [15:0] v;
    logic [15:0] exp_tbl [8];

    initial begin
        reset_n    = 1'b0;
        irq_in     = 8'h01;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 16'd0;
        #1;
        chk("rst_readdata", readdata, 16'h0000);
        chk("rst_irq", {15'd0, irq}, 16'h0000);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Line held high across reset, level mode by default.
        rd(3'd0, v); chk("rst_pending_level", v, 16'h0001);
        rd(3'd1, v); chk("rst_enable", v, 16'h0000);
        rd(3'd6, v); chk("rst_count", v, 16'h0000);
        wr(3'd2, 16'h00FF);
        rd(3'd2, v); chk("edge_sel_rb", v, 16'h00FF);
        rd(3'd0, v); chk("no_false_edge", v, 16'h0000);
        @(negedge clk); irq_in = 8'h00;
        repeat (2) @(negedge clk);
        irq_in = 8'h01;
        repeat (2) @(negedge clk);
        rd(3'd0, v); chk("edge_after_reedge", v, 16'h0001);

        // Single-cycle level pulse on bit 0.
        irq_in = 8'h00;
        wr(3'd3, 16'h00FF);
        wr(3'd2, 16'h0000);
        wr(3'd6, 16'h1234);
        wr(3'd1, 16'h0001);
        rd(3'd0, v); chk("pulse_pre_pending", v, 16'h0000);
        @(negedge clk); irq_in = 8'h01;
        #1 chk("pulse_irq_c0", {15'd0, irq}, 16'h0000);
        @(negedge clk); chk("pulse_irq_c1", {15'd0, irq}, 16'h0001);
        irq_in = 8'h00;
        @(negedge clk); chk("pulse_irq_c2", {15'd0, irq}, 16'h0000);
        rd(3'd6, v); chk("pulse_count", v, 16'h0001);

        // Edge bits 1 and 2, priority vector, clear one at a time.
        wr(3'd2, 16'h0006);
        wr(3'd1, 16'h0006);
        @(negedge clk); irq_in = 8'h06;
        repeat (2) @(negedge clk);
        irq_in = 8'h00;
        rd(3'd5, v); chk("vec_both", v, 16'h8001);
        wr(3'd3, 16'h0002);
        rd(3'd5, v); chk("vec_bit2", v, 16'h8002);
        wr(3'd3, 16'h0004);
        rd(3'd5, v); chk("vec_none", v, 16'h0000);
        chk("vec_none_irq", {15'd0, irq}, 16'h0000);
        rd(3'd6, v); chk("count_two", v, 16'h0002);

        // Edge and CLEAR on bit 3 in the same cycle.
        wr(3'd1, 16'h0000);
        wr(3'd2, 16'h0008);
        @(negedge clk);
        irq_in     = 8'h08;
        address    = 3'd3;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = 16'h0008;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        rd(3'd0, v); chk("set_wins_clear", v, 16'h0008);
        wr(3'd3, 16'h0008);
        rd(3'd0, v); chk("clear_alone", v, 16'h0000);
        irq_in = 8'h00;

        // FORCE in edge mode latches pending.
        wr(3'd2, 16'h0020);
        wr(3'd4, 16'h0020);
        rd(3'd0, v); chk("force_edge", v, 16'h0020);
        wr(3'd3, 16'h0020);
        rd(3'd0, v); chk("force_edge_clr", v, 16'h0000);

        // FORCE bit 7 in level mode drives irq two cycles after the write.
        wr(3'd2, 16'h0000);
        wr(3'd1, 16'h0080);
        @(negedge clk);
        address    = 3'd4;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = 16'h0080;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        chk("force_irq_c1", {15'd0, irq}, 16'h0000);
        @(negedge clk); chk("force_irq_c2", {15'd0, irq}, 16'h0001);
        rd(3'd0, v); chk("force_pending", v, 16'h0080);
        wr(3'd3, 16'h0080);
        chk("clr_irq_lag", {15'd0, irq}, 16'h0001);
        @(negedge clk); chk("clr_irq_low", {15'd0, irq}, 16'h0000);
        rd(3'd6, v); chk("count_three", v, 16'h0003);
        wr(3'd6, 16'h0000);
        rd(3'd6, v); chk("count_cleared", v, 16'h0000);

        // Reads without chipselect; one-cycle latency and full map.
        wr(3'd2, 16'h0040);
        irq_in = 8'h10;
        @(negedge clk); address = 3'd0;
        @(negedge clk); chk("rd_pending_cs0", readdata, 16'h0010);
        address = 3'd1;
        #1 chk("rd_latency_hold", readdata, 16'h0010);
        @(negedge clk); chk("rd_latency_upd", readdata, 16'h0080);
        exp_tbl = '{16'h0010, 16'h0080, 16'h0040, 16'h0000,
                    16'h0000, 16'h0000, 16'h0000, 16'h0000};
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), v);
            chk($sformatf("map_addr%0d", a), v, exp_tbl[a]);
        end

        // Asynchronous reset while irq is asserted.
        irq_in = 8'h00;
        wr(3'd2, 16'h0000);
        wr(3'd4, 16'h0080);
        @(negedge clk); address = 3'd1;
        @(negedge clk);
        chk("pre_rst_irq", {15'd0, irq}, 16'h0001);
        chk("pre_rst_rd", readdata, 16'h0080);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_irq", {15'd0, irq}, 16'h0000);
        chk("async_rst_rd", readdata, 16'h0000);
        @(negedge clk); reset_n = 1'b1;
        rd(3'd1, v); chk("post_rst_enable", v, 16'h0000);
        rd(3'd0, v); chk("post_rst_pending", v, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usb20sr_refdes_irq_ctrl.md
USB20SR_REFDES_IRQ_CTRL -- requirements
Module: usb20sr_refdes_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, number of interrupt sources (legal 1..16).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port irq_in  input  NUM_IRQ  peripheral interrupt lines (bit 0 = interval timer irq), synchronous to clk.
REQ-005 SHALL have port address  input  3  Avalon-MM slave word address.
REQ-006 SHALL have port chipselect  input  1  slave select.
REQ-007 SHALL have port write_n  input  1  active-low write strobe.
REQ-008 SHALL have port writedata  input  16  write data.
REQ-009 SHALL have port readdata  output  16  registered read data.
REQ-010 SHALL have port irq  output  1  aggregated interrupt to CPU.

Function
REQ-011 Register map SHALL be: 0 PENDING (RO), 1 ENABLE (RW), 2 EDGE_SEL (RW, 1=rising-edge latched, 0=level), 3 CLEAR (WO, write-1-to-clear), 4 FORCE (WO, write-1-to-set), 5 VECTOR (RO), 6 IRQ_COUNT (RO, write any value clears); address 7 reads 0.
REQ-012 Write strobe SHALL be chipselect && ~write_n; write takes effect at the next clk edge; bits above NUM_IRQ ignored.
REQ-013 readdata SHALL be registered every cycle from the address-decoded mux (1-cycle latency, chipselect not required); unused bits read 0; CLEAR/FORCE read 0.
REQ-014 Edge source i SHALL latch pending[i] on irq_in[i] 0->1 (delayed-copy compare), hold until CLEAR bit i is written.
REQ-015 Level source i SHALL have pending[i] = irq_in[i] | force_latch[i]; force_latch cleared by CLEAR.
REQ-016 FORCE bit i SHALL set pending[i] (edge) or force_latch[i] (level) next cycle.
REQ-017 Simultaneous set (edge or FORCE) and CLEAR on the same bit in the same cycle: set SHALL win.
REQ-018 Changing EDGE_SEL SHALL not alter existing latched state; the edge detector delayed-copy SHALL update every cycle regardless of mode.
REQ-019 active = pending & ENABLE; irq SHALL be registered |active, one cycle after active changes.
REQ-020 VECTOR SHALL read {bit15 = |active, bits[3:0] = lowest index with active set}, 0 in [14:0] when none active.
REQ-021 IRQ_COUNT SHALL increment on each 0->1 transition of registered irq, saturate at 16'hFFFF, clear on write (write wins over increment).

Reset
REQ-022 On reset_n low: PENDING, ENABLE, EDGE_SEL, force_latch, edge delayed-copy, IRQ_COUNT, readdata, irq all 0.
REQ-023 Reset SHALL take effect immediately and asynchronously mid-operation; first edge after release SHALL not see a false rising edge on inputs already high (delayed-copy resets to 0 only if input is 0 — implementation: delayed-copy loads irq_in on first cycle after reset, no latch that cycle).

Structure
REQ-024 Shared package SHALL hold register address constants (ADDR_PENDING..ADDR_IRQ_COUNT) and the NUM_IRQ maximum (16).
REQ-025 One sub-module SHALL exist: usb20sr_refdes_irq_prienc (NUM_IRQ-wide lowest-index priority encoder with valid output), purely combinational.

Verification
REQ-026 Reset release with irq_in=8'h01 held high, EDGE_SEL=0xFF written after -> no pending until irq_in falls and rises again; then PENDING reads 0x0001.
REQ-027 ENABLE=0x01, level mode, irq_in[0] pulses high 1 cycle -> irq high exactly 1 cycle, delayed 1 cycle; IRQ_COUNT reads 1.
REQ-028 EDGE_SEL=0x06, ENABLE=0x06, rising edges on bits 1 and 2 -> VECTOR reads 0x8001; CLEAR 0x02 -> VECTOR 0x8002; CLEAR 0x04 -> VECTOR 0x0000, irq low.
REQ-029 Edge on bit 3 in same cycle as CLEAR 0x08 (EDGE_SEL=0x08) -> PENDING bit 3 remains 1.
REQ-030 FORCE 0x80 with ENABLE=0x80, level mode, irq_in=0 -> irq asserts 2 cycles after write; CLEAR 0x80 -> irq deasserts.
REQ-031 Read each address with chipselect=0 -> readdata updates one cycle later; address 7 returns 0x0000.
